// File: rtl/btn_debounce.sv
// Multi-channel push-button conditioner: two-flop synchroniser, debounce FSM
// and optional auto-repeat per channel, producing a clean level plus pulses.
module btn_debounce #(
  parameter int NBTN         = 4,
  parameter int DEBOUNCE_CYC = 16,
  parameter int REPEAT_EN    = 1,
  parameter int REPEAT_DELAY = 64,
  parameter int REPEAT_RATE  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NBTN-1:0] btn_raw,
  output logic [NBTN-1:0] btn_level,
  output logic [NBTN-1:0] btn_press,
  output logic [NBTN-1:0] btn_release,
  output logic [NBTN-1:0] btn_repeat
);

  localparam int CW   = $clog2(DEBOUNCE_CYC);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX);

  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1'b1);
  localparam logic [RW-1:0] REP_FIRST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] REP_NEXT  = RW'(REPEAT_RATE - 1);
  localparam logic [RW-1:0] REP_ONE   = RW'(1'b1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DB_PRESS = 2'd1,
    HELD     = 2'd2,
    DB_REL   = 2'd3
  } state_t;

  logic [NBTN-1:0] sync1_r;
  logic [NBTN-1:0] sync2_r;
  logic [NBTN-1:0] first_r;
  state_t          state_r [NBTN];
  logic [CW-1:0]   cnt_r   [NBTN];
  logic [RW-1:0]   rep_r   [NBTN];

  // Two-flop synchroniser bringing the asynchronous pad levels into clk.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_r <= '0;
      sync2_r <= '0;
    end else begin
      sync1_r <= btn_raw;
      sync2_r <= sync1_r;
    end
  end

  // Per-channel debounce/auto-repeat FSM with registered level and pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      btn_repeat  <= '0;
      first_r     <= '0;
      for (int i = 0; i < NBTN; i++) begin
        state_r[i] <= IDLE;
        cnt_r[i]   <= '0;
        rep_r[i]   <= '0;
      end
    end else begin
      btn_press   <= '0;
      btn_release <= '0;
      btn_repeat  <= '0;
      for (int i = 0; i < NBTN; i++) begin
        case (state_r[i])
          IDLE: begin
            if (sync2_r[i]) begin
              state_r[i] <= DB_PRESS;
              cnt_r[i]   <= '0;
            end else begin
              state_r[i] <= IDLE;
            end
          end
          DB_PRESS: begin
            if (!sync2_r[i]) begin
              state_r[i] <= IDLE;
            end else if (cnt_r[i] == CNT_LAST) begin
              state_r[i]   <= HELD;
              btn_level[i] <= 1'b1;
              btn_press[i] <= 1'b1;
              rep_r[i]     <= '0;
              first_r[i]   <= 1'b1;
            end else begin
              cnt_r[i] <= cnt_r[i] + CNT_ONE;
            end
          end
          HELD: begin
            if (!sync2_r[i]) begin
              state_r[i] <= DB_REL;
              cnt_r[i]   <= '0;
            end else if (REPEAT_EN != 0) begin
              // The first repeat waits the longer delay, later ones the rate.
              if (rep_r[i] == (first_r[i] ? REP_FIRST : REP_NEXT)) begin
                btn_press[i]  <= 1'b1;
                btn_repeat[i] <= 1'b1;
                rep_r[i]      <= '0;
                first_r[i]    <= 1'b0;
              end else begin
                rep_r[i] <= rep_r[i] + REP_ONE;
              end
            end else begin
              rep_r[i] <= '0;
            end
          end
          DB_REL: begin
            if (sync2_r[i]) begin
              state_r[i] <= HELD;
              rep_r[i]   <= '0;
            end else if (cnt_r[i] == CNT_LAST) begin
              state_r[i]     <= IDLE;
              btn_level[i]   <= 1'b0;
              btn_release[i] <= 1'b1;
            end else begin
              cnt_r[i] <= cnt_r[i] + CNT_ONE;
            end
          end
          default: begin
            state_r[i] <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Scoreboard bench for btn_debounce: an edge-count reference model feeds
// per-cycle expectations to a monitor; directed checks pin the latencies.
module tb_btn_debounce;

  localparam int N  = 4;
  localparam int D  = 4;
  localparam int RD = 8;
  localparam int RR = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] raw = '0;
  logic [N-1:0] lv0, pr0, rl0, rp0;
  logic [N-1:0] lv1, pr1, rl1, rp1;

  always #5 clk = ~clk;

  btn_debounce #(.NBTN(N), .DEBOUNCE_CYC(D), .REPEAT_EN(1), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut0 (
    .clk(clk), .rst(rst), .btn_raw(raw),
    .btn_level(lv0), .btn_press(pr0), .btn_release(rl0), .btn_repeat(rp0)
  );

  btn_debounce #(.NBTN(N), .DEBOUNCE_CYC(D), .REPEAT_EN(0), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut1 (
    .clk(clk), .rst(rst), .btn_raw(raw),
    .btn_level(lv1), .btn_press(pr1), .btn_release(rl1), .btn_repeat(rp1)
  );

  typedef struct packed {
    logic [N-1:0] lvl;
    logic [N-1:0] prs;
    logic [N-1:0] rel;
    logic [N-1:0] rpt;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   total = 0;
  int   bad   = 0;

  // Reference state: edge numbers since reset, plus per-channel run lengths.
  int           edge_no = 0;
  logic [N-1:0] m_p1 = '0;
  logic [N-1:0] m_p2 = '0;
  int           m_run    [2][N];
  int           m_anchor [2][N];
  bit           m_first  [2][N];
  bit           m_level  [2][N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // A change is accepted after D+1 consecutive agreeing synchronised samples;
  // repeats fire RD (first) or RR edges after the last anchor in steady hold.
  task automatic model_step();
    exp_t         e [2];
    logic [N-1:0] s;
    int           thr;
    e[0] = '0;
    e[1] = '0;
    if (!rst) begin
      edge_no = 0;
      m_p1 = '0;
      m_p2 = '0;
      for (int d = 0; d < 2; d++) begin
        for (int c = 0; c < N; c++) begin
          m_run[d][c] = 0; m_anchor[d][c] = 0; m_first[d][c] = 0; m_level[d][c] = 0;
        end
      end
    end else begin
      edge_no++;
      s    = m_p2;
      m_p2 = m_p1;
      m_p1 = raw;
      for (int d = 0; d < 2; d++) begin
        for (int c = 0; c < N; c++) begin
          if (!m_level[d][c]) begin
            m_run[d][c] = s[c] ? m_run[d][c] + 1 : 0;
            if (m_run[d][c] == D + 1) begin
              m_level[d][c] = 1; m_run[d][c] = 0;
              m_anchor[d][c] = edge_no; m_first[d][c] = 1;
              e[d].prs[c] = 1'b1;
            end
          end else if (!s[c]) begin
            m_run[d][c]++;
            if (m_run[d][c] == D + 1) begin
              m_level[d][c] = 0; m_run[d][c] = 0;
              e[d].rel[c] = 1'b1;
            end
          end else if (m_run[d][c] != 0) begin
            m_run[d][c] = 0;
            m_anchor[d][c] = edge_no;
          end else begin
            thr = m_first[d][c] ? RD : RR;
            if (d == 0 && edge_no - m_anchor[d][c] == thr) begin
              e[d].prs[c] = 1'b1; e[d].rpt[c] = 1'b1;
              m_anchor[d][c] = edge_no; m_first[d][c] = 0;
            end
          end
          e[d].lvl[c] = m_level[d][c];
        end
      end
    end
    q0.push_back(e[0]);
    q1.push_back(e[1]);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Monitor: every cycle the DUTs present outputs, pop and compare.
  initial begin
    exp_t e0, e1;
    forever begin
      @(posedge clk);
      #1;
      chk("sb_depth", 64'(q0.size()), 64'd1);
      if (q0.size() > 0 && q1.size() > 0) begin
        e0 = q0.pop_front();
        e1 = q1.pop_front();
        chk("d0_level",   64'(lv0), 64'(e0.lvl));
        chk("d0_press",   64'(pr0), 64'(e0.prs));
        chk("d0_release", 64'(rl0), 64'(e0.rel));
        chk("d0_repeat",  64'(rp0), 64'(e0.rpt));
        chk("d1_level",   64'(lv1), 64'(e1.lvl));
        chk("d1_press",   64'(pr1), 64'(e1.prs));
        chk("d1_release", 64'(rl1), 64'(e1.rel));
        chk("d1_repeat",  64'(rp1), 64'(e1.rpt));
      end
    end
  end

  task automatic find_edge(input int ch, input int kind, input int maxe, output int at);
    at = 0;
    for (int i = 1; i <= maxe; i++) begin
      @(posedge clk);
      #1;
      if (at == 0 && ((kind == 0) ? pr0[ch] : rl0[ch])) at = i;
    end
  endtask

  initial begin
    int          at;
    logic [63:0] pm0, rm0, pm1, exp_pm, exp_rm;
    logic [N-1:0] simul;
    int          rep_edges [5] = '{15, 19, 23, 27, 31};
    int          p;
    int          choices [3] = '{2, 12, 40};

    repeat (3) @(negedge clk);
    chk("reset_level", 64'(lv0 | pr0 | rl0 | rp0), 64'd0);
    rst = 1'b1;

    // clean press on channel 0
    @(negedge clk); raw[0] = 1'b1;
    find_edge(0, 0, 20, at);
    chk("press_latency", 64'(at), 64'd7);
    repeat (5) @(negedge clk);

    // release of channel 0
    raw[0] = 1'b0;
    find_edge(0, 1, 20, at);
    chk("release_latency", 64'(at), 64'd7);
    repeat (20) @(negedge clk);

    // bounce on channel 1
    raw[1] = 1'b1; repeat (2) @(negedge clk);
    raw[1] = 1'b0; repeat (2) @(negedge clk);
    raw[1] = 1'b1; repeat (2) @(negedge clk);
    raw[1] = 1'b0;
    find_edge(1, 0, 20, at);
    chk("bounce_press", 64'(at), 64'd0);
    chk("bounce_level", 64'(lv0[1]), 64'd0);

    // auto-repeat on channel 2
    @(negedge clk); raw[2] = 1'b1;
    pm0 = '0; rm0 = '0; pm1 = '0;
    for (int i = 1; i <= 32; i++) begin
      @(posedge clk);
      #1;
      pm0[i] = pr0[2];
      rm0[i] = rp0[2];
      pm1[i] = pr1[2];
    end
    exp_rm = '0;
    foreach (rep_edges[k]) exp_rm[rep_edges[k]] = 1'b1;
    exp_pm = exp_rm;
    exp_pm[7] = 1'b1;
    chk("repeat_press_edges", pm0, exp_pm);
    chk("repeat_flag_edges", rm0, exp_rm);
    chk("norepeat_press_edges", pm1, 64'h80);
    @(negedge clk); raw[2] = 1'b0;
    repeat (20) @(negedge clk);

    // reset while channel 0 is held
    raw[0] = 1'b1;
    repeat (12) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("midhold_reset_out", 64'({lv0, pr0, rl0, rp0}), 64'd0);
    rst = 1'b1;
    find_edge(0, 0, 20, at);
    chk("reset_repress_latency", 64'(at), 64'd7);
    @(negedge clk); raw[0] = 1'b0;
    repeat (20) @(negedge clk);

    // simultaneous press
    raw = 4'b1011;
    simul = '0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (simul == '0 && pr0 != '0) simul = pr0;
    end
    chk("simultaneous_press", 64'(simul), 64'hb);
    @(negedge clk); raw = '0;
    repeat (20) @(negedge clk);

    // randomized segments with varying bounce density and rare resets
    for (int seg = 0; seg < 15; seg++) begin
      p = choices[$urandom_range(0, 2)];
      for (int k = 0; k < 200; k++) begin
        @(negedge clk);
        for (int c = 0; c < N; c++) begin
          if ($urandom_range(0, p - 1) == 0) raw[c] = ~raw[c];
        end
        rst = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      end
    end

    @(negedge clk); rst = 1'b1; raw = '0;
    repeat (20) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
- Multi-channel push-button conditioner for the calculator front panel.
- Each raw button input passes through a two-flop synchroniser, a debounce FSM, and an optional auto-repeat generator.
- Outputs are a clean level plus single-cycle press, release and repeat pulses.
- Sits directly downstream of the pads and feeds the calculator's key/operand input logic.

Parameters:
- NBTN, 4, number of independent button channels.
- DEBOUNCE_CYC, 16, consecutive stable synchronised cycles required to accept a change; must be >= 2. Synthesis overrides to ~500000.
- REPEAT_EN, 1, 1 enables auto-repeat press pulses while held; 0 disables.
- REPEAT_DELAY, 64, held cycles before the first repeat pulse; >= 2.
- REPEAT_RATE, 16, cycles between subsequent repeat pulses; >= 2.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous reset, active-low (0 = reset), sampled on posedge clk.
- btn_raw  in  NBTN  asynchronous raw button levels, 1 = pressed.
- btn_level  out  NBTN  debounced level per channel.
- btn_press  out  NBTN  one-cycle pulse on accepted press, and on each auto-repeat.
- btn_release  out  NBTN  one-cycle pulse on accepted release.
- btn_repeat  out  NBTN  one-cycle pulse coincident with btn_press only when that pulse is an auto-repeat.

Behaviour:
- Reset (rst=0 at posedge): sync flops, counters and repeat flags are 0; every FSM is in IDLE; all outputs are 0.
- Reset mid-debounce or mid-hold aborts with no pulse. A button still held when rst returns to 1 is re-detected with full latency.
- Synchroniser: s = btn_raw delayed by two flops. The FSM uses only s.
- Per-channel FSM, all outputs registered:
  - IDLE: s=1 -> DB_PRESS, cnt<=0.
  - DB_PRESS:
    - s=0 -> IDLE, no output (bounce).
    - else if cnt==DEBOUNCE_CYC-1 -> HELD, btn_level<=1, btn_press pulse, rep<=0, first<=1.
    - else cnt++.
  - HELD:
    - s=0 -> DB_REL, cnt<=0.
    - else, if REPEAT_EN: rep++. When rep==(first ? REPEAT_DELAY-1 : REPEAT_RATE-1): btn_press and btn_repeat pulse, rep<=0, first<=0.
  - DB_REL:
    - s=1 -> HELD, no pulse, rep<=0; the first flag is kept.
    - else if cnt==DEBOUNCE_CYC-1 -> IDLE, btn_level<=0, btn_release pulse.
    - else cnt++.
- Latency:
  - Counting the first posedge that samples btn_raw=1 as edge 1, btn_press is high in the cycle after edge DEBOUNCE_CYC+3.
  - Release latency is identical.
  - First repeat: REPEAT_DELAY edges after the edge that entered HELD. Subsequent repeats every REPEAT_RATE edges.
- Pulses are exactly 1 cycle wide. btn_press and btn_release are never high in the same cycle on one channel.
- Channels are fully independent. Simultaneous events on several channels produce pulses in the same cycle.
- Counter widths are sized by $clog2 of the largest compared value; counters never wrap in normal operation.

Test Plan:
(All scenarios use overrides DEBOUNCE_CYC=4, REPEAT_DELAY=8, REPEAT_RATE=4, NBTN=4.)
- Clean press: btn_raw[0] 0->1 held -> btn_press[0] high for exactly 1 cycle after edge 7; btn_level[0]=1 from the same cycle; other channels stay 0.
- Bounce rejection: btn_raw[1] toggles 1,0,1,0 with 2-cycle periods, then stays 0 -> no btn_press, no btn_level change.
- Release: after a held press, btn_raw[0] 1->0 -> btn_release[0] 1 cycle after edge 7 of release; btn_level[0]=0.
- Auto-repeat: hold btn_raw[2] for 30 cycles -> press at edge 7, then press+repeat pulses at edges 15, 19, 23, 27, 31 (counting from raw edge 1); repeat never set on the edge-7 press. With REPEAT_EN=0 -> only the edge-7 press.
- Reset mid-hold: rst=0 for 2 cycles during HELD with raw still 1 -> outputs 0 during reset; after rst=1, new press pulse 7 edges later, no release pulse.
- Simultaneous: btn_raw=4'b1011 asserted together -> btn_press=4'b1011 in one single cycle.
